// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: stalls, flushes and PC redirect.
// Optional event counters enabled by defining HAZARD_PERF_EN.
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic        e_memread,
    input  logic        e_regwrite,
    input  logic [4:0]  e_wa,
    input  logic        jump,
    input  logic [63:0] pcsrc,
    input  logic        i_busy,
    input  logic        i_ok,
    input  logic        d_busy,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        flushD,
    output logic        flushE,
    output logic        flushW,
    output logic        redirect,
    output logic [63:0] redirect_pc
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_lu,
    output logic [31:0] perf_mem,
    output logic [31:0] perf_redir
`endif
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] JWAIT = 1'b1;

    logic [0:0]  state;
    logic [0:0]  state_nxt;
    logic [63:0] tgt;
    logic        load_tgt;
    logic        lu;
    logic        stall_d_raw;

    assign lu = e_memread & e_regwrite & (e_wa != 5'd0) &
                ((e_wa == ra1) | (e_wa == ra2));

    always_comb begin
        state_nxt   = state;
        load_tgt    = 1'b0;
        stallF      = 1'b0;
        stall_d_raw = 1'b0;
        stallE      = 1'b0;
        stallM      = 1'b0;
        flushD      = 1'b0;
        flushE      = 1'b0;
        flushW      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 64'd0;
        if (!reset) begin
            // Wrong-path fetch in flight; redirect lands regardless of d_busy.
            if (state == JWAIT) begin
                flushD = 1'b1;
                stallF = !i_ok;
                if (i_ok) begin
                    redirect    = 1'b1;
                    redirect_pc = tgt;
                    state_nxt   = RUN;
                end
            end
            if (d_busy) begin
                stallF      = 1'b1;
                stall_d_raw = 1'b1;
                stallE      = 1'b1;
                stallM      = 1'b1;
                flushW      = 1'b1;
            end else if (lu) begin
                stallF      = 1'b1;
                stall_d_raw = 1'b1;
                flushE      = 1'b1;
            end else if (state == RUN) begin
                if (jump && !i_busy) begin
                    redirect    = 1'b1;
                    redirect_pc = pcsrc;
                    flushD      = 1'b1;
                end else if (jump) begin
                    flushD    = 1'b1;
                    stallF    = 1'b1;
                    load_tgt  = 1'b1;
                    state_nxt = JWAIT;
                end else if (i_busy) begin
                    stallF      = 1'b1;
                    stall_d_raw = 1'b1;
                    flushE      = 1'b1;
                end
            end
        end
        stallD = stall_d_raw & ~flushD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            tgt   <= 64'd0;
        end else begin
            state <= state_nxt;
            if (load_tgt)
                tgt <= pcsrc;
        end
    end

`ifdef HAZARD_PERF_EN
    logic lu_fire;

    assign lu_fire = !reset && !d_busy && lu;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_lu    <= 32'd0;
            perf_mem   <= 32'd0;
            perf_redir <= 32'd0;
        end else begin
            if (lu_fire && perf_lu != 32'hFFFF_FFFF)
                perf_lu <= perf_lu + 32'd1;
            if (d_busy && perf_mem != 32'hFFFF_FFFF)
                perf_mem <= perf_mem + 32'd1;
            if (redirect && perf_redir != 32'hFFFF_FFFF)
                perf_redir <= perf_redir + 32'd1;
        end
    end
`endif

endmodule
